// File: rtl/line_buffer_pkg.sv
// Shared types and width helpers for the 3-row line buffer feeder.
// The DRAIN encoding is always declared; it is only reachable when ZERO_PAD_EN is defined.
package line_buffer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        STREAM    = 3'd2,
        DRAIN     = 3'd3,
        WAIT_LAST = 3'd4
    } state_t;

    // Counter width for a dimension of n entries, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_FEATURE_MAP_WIDTH  = 1024;
    localparam int DEF_FEATURE_MAP_HEIGHT = 1024;
    localparam int DEF_X_W = cnt_w(DEF_FEATURE_MAP_WIDTH);
    localparam int DEF_Y_W = cnt_w(DEF_FEATURE_MAP_HEIGHT);

endpackage

// File: rtl/line_buffer_feeder_line_mem.sv
// One row store: synchronous write, asynchronous read, so a same-cycle read
// returns the value from before that cycle's write. Contents are not reset.
module line_mem #(
    parameter int DEPTH = 1024,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/line_buffer_feeder.sv
// Raster pixel stream to 3-row columns using two row stores and one output register.
// Optional top/bottom zero padding with a trailing DRAIN row is enabled by ZERO_PAD_EN.
module line_buffer_feeder
    import line_buffer_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024
) (
    input  logic                                  clk,
    input  logic                                  arst_n_in,
    input  logic                                  start,
    output logic                                  running,
    input  logic [IO_DATA_WIDTH-1:0]              pix_in,
    input  logic                                  pix_valid,
    output logic                                  pix_ready,
    output logic [IO_DATA_WIDTH-1:0]              col0,
    output logic [IO_DATA_WIDTH-1:0]              col1,
    output logic [IO_DATA_WIDTH-1:0]              col2,
    output logic                                  col_valid,
    input  logic                                  col_ready,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  col_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] col_y,
    output state_t                                dbg_state
);

    localparam int XW = cnt_w(FEATURE_MAP_WIDTH);
    localparam int YW = cnt_w(FEATURE_MAP_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FEATURE_MAP_HEIGHT - 1);
`ifdef ZERO_PAD_EN
    localparam logic [YW-1:0] FILL_LAST_ROW = '0;
`else
    localparam logic [YW-1:0] FILL_LAST_ROW = YW'(1);
`endif

    state_t state, state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [IO_DATA_WIDTH-1:0] line0_rd, line1_rd;
    logic accept, load, drain_load, out_free, x_last, y_last;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // output register holds col* stable while col_valid && !col_ready.
    assign accept   = pix_valid && pix_ready;
    assign out_free = !col_valid || col_ready;
    assign x_last   = (x == X_LAST);
    assign y_last   = (y == Y_LAST);
    assign running  = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        load       = 1'b0;
        drain_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                pix_ready = 1'b1;
                if (accept && x_last && (y == FILL_LAST_ROW)) state_nxt = STREAM;
            end
            STREAM: begin
                pix_ready = out_free;
                load      = accept;
                if (accept && x_last && y_last) begin
`ifdef ZERO_PAD_EN
                    state_nxt = DRAIN;
`else
                    state_nxt = WAIT_LAST;
`endif
                end
            end
`ifdef ZERO_PAD_EN
            DRAIN: begin
                drain_load = out_free;
                if (out_free && x_last) state_nxt = WAIT_LAST;
            end
`endif
            WAIT_LAST: begin
                if (col_valid && col_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // y is held at the last row through DRAIN so drained columns report it.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            x <= '0;
            y <= '0;
        end else if ((state == IDLE) || (state_nxt == WAIT_LAST)) begin
            x <= '0;
            y <= '0;
        end else if (accept || drain_load) begin
            if (x_last) begin
                x <= '0;
                if (!y_last) y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            col0      <= '0;
            col1      <= '0;
            col2      <= '0;
            col_x     <= '0;
            col_y     <= '0;
            col_valid <= 1'b0;
        end else if (load) begin
`ifdef ZERO_PAD_EN
            col0 <= (y == YW'(1)) ? '0 : line0_rd;
`else
            col0 <= line0_rd;
`endif
            col1      <= line1_rd;
            col2      <= pix_in;
            col_x     <= x;
            col_y     <= y - 1'b1;
            col_valid <= 1'b1;
        end else if (drain_load) begin
            col0      <= line0_rd;
            col1      <= line1_rd;
            col2      <= '0;
            col_x     <= x;
            col_y     <= y;
            col_valid <= 1'b1;
        end else if (col_ready) begin
            col_valid <= 1'b0;
        end
    end

    line_mem #(.DEPTH(FEATURE_MAP_WIDTH), .DW(IO_DATA_WIDTH)) u_line0 (
        .clk   (clk),
        .we    (accept),
        .waddr (x),
        .wdata (line1_rd),
        .raddr (x),
        .rdata (line0_rd)
    );

    line_mem #(.DEPTH(FEATURE_MAP_WIDTH), .DW(IO_DATA_WIDTH)) u_line1 (
        .clk   (clk),
        .we    (accept),
        .waddr (x),
        .wdata (pix_in),
        .raddr (x),
        .rdata (line1_rd)
    );

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Bench for line_buffer_feeder at W=4, H=4; expected columns come from a frame-level
// neighbourhood model. Also valid with ZERO_PAD_EN defined.
module tb_line_buffer_feeder;
  import line_buffer_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int CW = 3 * DW + XW + YW;
`ifdef ZERO_PAD_EN
  localparam int NCOLS = W * H;
  localparam int FIRST_PIX = W;
`else
  localparam int NCOLS = W * (H - 2);
  localparam int FIRST_PIX = 2 * W;
`endif
  localparam int TIMEOUT = 3000;

  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  logic start = 1'b0;
  logic running;
  logic [DW-1:0] pix_in = '0;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic [DW-1:0] col0, col1, col2;
  logic col_valid;
  logic col_ready;
  logic [XW-1:0] col_x;
  logic [YW-1:0] col_y;
  state_t dbg_state;

  logic rand_ready = 1'b1;
  logic bp_force = 1'b0;
  bit rand_bp = 1'b0;
  assign col_ready = rand_ready && !bp_force;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pix_acc = 0;
  int pix_idx = 0;
  int first_valid_cyc = -1;
  logic last_hs_running = 1'b0;

  logic [DW-1:0] frame [H][W];
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] got_q[$];
  int hs_cyc_q[$];
  int pix_cyc_q[$];

  line_buffer_feeder #(
    .IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .col0(col0), .col1(col1), .col2(col2), .col_valid(col_valid),
    .col_ready(col_ready), .col_x(col_x), .col_y(col_y), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rand_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor (records, never judges) ----------------
  always @(negedge clk) begin
    if (arst_n_in) begin
      if (pix_valid && pix_ready) begin
        pix_acc++;
        pix_cyc_q.push_back(cyc);
      end
      if (col_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (col_valid && col_ready) begin
        got_q.push_back({col0, col1, col2, col_x, col_y});
        hs_cyc_q.push_back(cyc);
        last_hs_running = running;
      end
    end
  end

  // ---------------- reference model ----------------
  // Column for centre row r is the vertical 3-neighbourhood; outside rows read 0.
  function automatic void build_expected();
    int r0, r1;
    logic [DW-1:0] a, b, c;
`ifdef ZERO_PAD_EN
    r0 = 0; r1 = H - 1;
`else
    r0 = 1; r1 = H - 2;
`endif
    for (int r = r0; r <= r1; r++) begin
      for (int xx = 0; xx < W; xx++) begin
        a = (r - 1 >= 0) ? frame[r-1][xx] : '0;
        b = frame[r][xx];
        c = (r + 1 < H) ? frame[r+1][xx] : '0;
        exp_q.push_back({a, b, c, XW'(xx), YW'(r)});
      end
    end
  endfunction

  task automatic fill_pattern();
    for (int r = 0; r < H; r++)
      for (int xx = 0; xx < W; xx++)
        frame[r][xx] = DW'(r * 16 + xx);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int xx = 0; xx < W; xx++)
        frame[r][xx] = DW'($urandom_range(0, 16'hffff));
  endtask

  // ---------------- driver tasks (aligned to posedge+1) ----------------
  task automatic clear_sb();
    got_q.delete(); exp_q.delete(); hs_cyc_q.delete(); pix_cyc_q.delete();
    pix_acc = 0; pix_idx = 0; first_valid_cyc = -1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit gaps);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          pix_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      pix_valid = 1'b1;
      pix_in = frame[pix_idx / W][pix_idx % W];
      t = 0;
      forever begin
        @(negedge clk);
        acc = pix_ready;
        @(posedge clk); #1;
        if (acc) break;
        t++;
        if (t > TIMEOUT) begin
          checks++; failures++;
          $display("FAIL pix_accept_timeout idx=%0d waited=%0d limit=%0d", pix_idx, t, TIMEOUT);
          pix_valid = 1'b0;
          return;
        end
      end
      pix_idx++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_cols(input int n, input string tag);
    int t = 0;
    while (got_q.size() < n) begin
      @(posedge clk); #2;
      t++;
      if (t > TIMEOUT) begin
        checks++; failures++;
        $display("FAIL %s col_timeout got=%0d exp=%0d", tag, got_q.size(), n);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({running, pix_ready, col_valid} !== 3'b000) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=000", {running, pix_ready, col_valid});
    end
    checks++;
    if ({col0, col1, col2, col_x, col_y} !== '0) begin
      failures++;
      $display("FAIL rst_cols got=%h exp=0", {col0, col1, col2, col_x, col_y});
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE);
    end
    // pixels offered while idle must not be taken
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pix_ready !== 1'b0 || pix_acc != 0) begin
      failures++;
      $display("FAIL idle_ready got=%b/%0d exp=0/0", pix_ready, pix_acc);
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    logic [CW-1:0] first_c, last_c;
    clear_sb(); fill_pattern(); build_expected();
    do_start();
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL ff_running_after_start got=%b exp=1", running);
    end
    drive_pixels(W * H, 1'b0);
    wait_cols(NCOLS, "ff");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ff_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ff_col[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
`ifdef ZERO_PAD_EN
    first_c = {16'h0000, 16'h0000, 16'h0010, 2'd0, 2'd0};
    last_c  = {16'h0023, 16'h0033, 16'h0000, 2'd3, 2'd3};
`else
    first_c = {16'h0000, 16'h0010, 16'h0020, 2'd0, 2'd1};
    last_c  = {16'h0013, 16'h0023, 16'h0033, 2'd3, 2'd2};
`endif
    if (got_q.size() == NCOLS) begin
      checks++;
      if (got_q[0] !== first_c) begin
        failures++;
        $display("FAIL ff_first got=%h exp=%h", got_q[0], first_c);
      end
      checks++;
      if (got_q[NCOLS-1] !== last_c) begin
        failures++;
        $display("FAIL ff_last got=%h exp=%h", got_q[NCOLS-1], last_c);
      end
    end
    if (pix_cyc_q.size() > FIRST_PIX) begin
      checks++;
      if (first_valid_cyc - pix_cyc_q[FIRST_PIX] != 1) begin
        failures++;
        $display("FAIL ff_latency got=%0d exp=1", first_valid_cyc - pix_cyc_q[FIRST_PIX]);
      end
    end
    checks++;
    if (running !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL ff_end_idle got=%b/%0d exp=0/%0d", running, dbg_state, IDLE);
    end
  endtask

  task automatic test_throughput();
    clear_sb(); fill_random(); build_expected();
    do_start();
    drive_pixels(W * H, 1'b0);
    wait_cols(NCOLS, "tp");
    checks++;
    if (hs_cyc_q.size() != NCOLS) begin
      failures++;
      $display("FAIL tp_count got=%0d exp=%0d", hs_cyc_q.size(), NCOLS);
    end else if (hs_cyc_q[NCOLS-1] - hs_cyc_q[0] != NCOLS - 1) begin
      failures++;
      $display("FAIL tp_span got=%0d exp=%0d", hs_cyc_q[NCOLS-1] - hs_cyc_q[0], NCOLS - 1);
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] snap;
    int t = 0;
    clear_sb(); fill_pattern(); build_expected();
    do_start();
    fork
      drive_pixels(W * H, 1'b0);
      begin
        while (pix_acc < 2 * W + 2 && t < TIMEOUT) begin
          @(posedge clk); #2; t++;
        end
        bp_force = 1'b1;
        @(negedge clk);
        snap = {col0, col1, col2, col_x, col_y};
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (col_valid !== 1'b1 || pix_ready !== 1'b0 ||
              {col0, col1, col2, col_x, col_y} !== snap) begin
            failures++;
            $display("FAIL bp_hold got=%b/%b/%h exp=1/0/%h", col_valid, pix_ready,
                     {col0, col1, col2, col_x, col_y}, snap);
          end
        end
        @(posedge clk); #1;
        bp_force = 1'b0;
      end
    join
    wait_cols(NCOLS, "bp");
    checks++;
    if (got_q.size() != exp_q.size() || pix_acc != W * H) begin
      failures++;
      $display("FAIL bp_count got=%0d/%0d exp=%0d/%0d", got_q.size(), pix_acc, exp_q.size(), W * H);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_col[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int t = 0;
    clear_sb(); fill_pattern(); build_expected();
    do_start();
    fork
      drive_pixels(W * H, 1'b0);
      begin
        while (pix_acc < 2 && t < TIMEOUT) begin
          @(posedge clk); #2; t++;
        end
        @(posedge clk); #1;
        do_start();
      end
    join
    wait_cols(NCOLS, "si");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL si_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL si_col[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (last_hs_running !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL si_running got=%b/%b exp=1/0", last_hs_running, running);
    end
  endtask

  task automatic test_random();
    rand_bp = 1'b1;
    for (int f = 0; f < 3; f++) begin
      clear_sb(); fill_random(); build_expected();
      do_start();
      drive_pixels(W * H, 1'b1);
      wait_cols(NCOLS, "rnd");
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rnd_count f=%0d got=%0d exp=%0d", f, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rnd_col[%0d] f=%0d got=%h exp=%h", i, f, got_q[i], exp_q[i]);
        end
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_bp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stream();
    clear_sb(); fill_random();
    do_start();
    drive_pixels(9, 1'b0);
    arst_n_in = 1'b0;
    #1;
    checks++;
    if ({col_valid, running, pix_ready} !== 3'b000 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL mid_rst got=%b/%0d exp=000/%0d", {col_valid, running, pix_ready},
               dbg_state, IDLE);
    end
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_sb(); fill_pattern(); build_expected();
    do_start();
    drive_pixels(W * H, 1'b0);
    wait_cols(NCOLS, "mr");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL mr_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL mr_col[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    test_full_frame();
    test_throughput();
    test_backpressure();
    test_start_ignored();
    test_random();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
